// File: rtl/mem_pkg.sv
// Shared definitions for the instruction/data memory arbiter: FSM encoding,
// default starvation limit and the wait-counter width helper.
package mem_pkg;

    localparam int MAX_WAIT_DEFAULT = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    // Wide enough to hold max_wait, never narrower than 2 bits.
    function automatic int cnt_width(input int max_wait);
        int w;
        w = $clog2(max_wait + 1);
        return (w < 2) ? 2 : w;
    endfunction

endpackage

// File: rtl/starve_counter.sv
// Counts data grants issued while a fetch is waiting; flags when the fetch
// must be forced through on the next arbitration.
module starve_counter
    import mem_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT,
    parameter int CNT_W    = cnt_width(MAX_WAIT)
) (
    input  logic clk,
    input  logic reset,
    input  logic i_if_req,
    input  logic i_data_grant,
    input  logic i_fetch_grant,
    output logic o_starved
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_fetch_grant || !i_if_req) begin
            r_cnt <= '0;
        end else if (i_data_grant && (r_cnt != MAX_CNT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_starved = (r_cnt == MAX_CNT);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one single-port
// memory; data wins ties unless the fetch has been starved for MAX_WAIT grants.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ack,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              stall_if,
    output logic              stall_mem
);

    state_t            r_state;
    state_t            w_next_state;
    logic              w_grant_i;
    logic              w_grant_d;
    logic              w_starved;
    logic              r_m_req;
    logic              r_m_we;
    logic [ADDR_W-1:0] r_m_addr;
    logic [DATA_W-1:0] r_m_wdata;
    logic              r_if_ack;
    logic              r_d_ack;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;

    starve_counter #(.MAX_WAIT(MAX_WAIT)) u_starve (
        .clk          (clk),
        .reset        (reset),
        .i_if_req     (if_req),
        .i_data_grant (w_grant_d),
        .i_fetch_grant(w_grant_i),
        .o_starved    (w_starved)
    );

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        // NOTE: defaults first, so no path through the case leaves a signal
        // unassigned and infers a latch.
        w_next_state = r_state;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        case (r_state)
            IDLE: begin
                if (if_req && (w_starved || !d_req)) begin
                    w_grant_i    = 1'b1;
                    w_next_state = BUSY_I;
                end else if (d_req) begin
                    w_grant_d    = 1'b1;
                    w_next_state = BUSY_D;
                end
            end
            BUSY_I, BUSY_D: begin
                if (m_ack) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: the data registers are reset as well, so an abandoned access
    // leaves every output at zero instead of stale bus contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_m_req    <= 1'b0;
            r_m_we     <= 1'b0;
            r_m_addr   <= '0;
            r_m_wdata  <= '0;
            r_if_ack   <= 1'b0;
            r_d_ack    <= 1'b0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else begin
            r_if_ack <= 1'b0;
            r_d_ack  <= 1'b0;
            if (w_grant_i) begin
                r_m_req   <= 1'b1;
                r_m_we    <= 1'b0;
                r_m_addr  <= if_addr;
                r_m_wdata <= '0;
            end else if (w_grant_d) begin
                r_m_req   <= 1'b1;
                r_m_we    <= d_we;
                r_m_addr  <= d_addr;
                r_m_wdata <= d_wdata;
            end else if (m_ack && (r_state == BUSY_I)) begin
                r_m_req    <= 1'b0;
                r_if_ack   <= 1'b1;
                r_if_rdata <= m_rdata;
            end else if (m_ack && (r_state == BUSY_D)) begin
                r_m_req <= 1'b0;
                r_d_ack <= 1'b1;
                if (!r_m_we) r_d_rdata <= m_rdata;
            end
        end
    end

    assign m_req     = r_m_req;
    assign m_we      = r_m_we;
    assign m_addr    = r_m_addr;
    assign m_wdata   = r_m_wdata;
    assign if_ack    = r_if_ack;
    assign d_ack     = r_d_ack;
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;
    // The requester may replace or drop its request in the ack cycle itself.
    assign stall_if  = if_req & ~r_if_ack;
    assign stall_mem = d_req & ~r_d_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: drivers per port, a latency-programmable
// memory responder, and monitors that pop expected grants and acks.
module tb_mem_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req, if_ack, d_req, d_we, d_ack;
    logic [AW-1:0] if_addr, d_addr, m_addr;
    logic [DW-1:0] if_rdata, d_wdata, d_rdata, m_wdata, m_rdata;
    logic          m_req, m_we, m_ack, stall_if, stall_mem;

    mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_WAIT(3)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        bit            chk_wdata;
    } grant_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        bit            drop;
    } d_item_t;

    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    grant_t        grant_q[$];
    logic [DW-1:0] if_exp_q[$];
    logic [DW-1:0] d_exp_q[$];
    logic [AW-1:0] if_stim_q[$];
    d_item_t       d_stim_q[$];
    logic [DW-1:0] mem [logic [AW-1:0]];
    int            lat = 1;
    int            inject_req = 0;
    int            inject_done = 0;
    bit            drv_abort = 1'b0;
    bit            if_busy = 1'b0;
    bit            d_busy = 1'b0;
    int            if_start_cyc = 0;
    int            if_last_lat = 0;
    int            if_ack_cnt = 0;
    int            d_ack_cnt = 0;
    int            d_last_ack_cyc = 0;
    int            d_prev_ack_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic exp_grant(input logic we, input logic [AW-1:0] a,
                             input logic [DW-1:0] wd, input bit cw);
        grant_t g;
        g.we = we; g.addr = a; g.wdata = wd; g.chk_wdata = cw;
        grant_q.push_back(g);
    endtask

    task automatic push_d(input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input bit drop);
        d_item_t it;
        it.we = we; it.addr = a; it.wdata = wd; it.drop = drop;
        d_stim_q.push_back(it);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (n < 300 && !(if_stim_q.size() == 0 && d_stim_q.size() == 0 &&
                   !if_busy && !d_busy && grant_q.size() == 0 &&
                   if_exp_q.size() == 0 && d_exp_q.size() == 0));
        if (n >= 300) fail_now({name, "_idle_timeout"});
    endtask

    // Memory model: acks lat cycles after first seeing m_req.
    initial begin
        m_ack   = 1'b0;
        m_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (inject_done != inject_req) begin
                inject_done = inject_req;
                m_rdata = 32'hBAD0_BAD0;
                m_ack   = 1'b1;
                @(posedge clk); #1;
                m_ack   = 1'b0;
            end else if (m_req === 1'b1) begin
                repeat (lat) @(posedge clk);
                #1;
                if (m_we) mem[m_addr] = m_wdata;
                else      m_rdata = mem.exists(m_addr) ? mem[m_addr] : '0;
                m_ack = 1'b1;
                @(posedge clk); #1;
                m_ack = 1'b0;
            end
        end
    end

    // Fetch requester: holds if_req until if_ack, may re-issue in the ack cycle.
    initial begin
        int wdog;
        wdog    = 0;
        if_req  = 1'b0;
        if_addr = '0;
        forever begin
            @(posedge clk); #1;
            if (if_busy) begin
                if (drv_abort) begin
                    if_busy = 1'b0; if_req = 1'b0;
                end else if (if_ack) begin
                    if_busy = 1'b0; if_req = 1'b0;
                    if_last_lat = cyc - if_start_cyc;
                end else begin
                    wdog++;
                    if (wdog > 60) begin
                        fail_now("if_ack_timeout");
                        if_busy = 1'b0; if_req = 1'b0;
                    end
                end
            end
            if (!if_busy && !drv_abort && if_stim_q.size() > 0) begin
                if_addr = if_stim_q.pop_front();
                if_req  = 1'b1;
                if_busy = 1'b1;
                wdog    = 0;
                if_start_cyc = cyc;
            end
        end
    end

    // Data requester: optionally drops d_req one cycle after asserting it.
    initial begin
        int      wdog;
        bit      drop_pend;
        d_item_t it;
        wdog = 0; drop_pend = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        forever begin
            @(posedge clk); #1;
            if (d_busy) begin
                if (drv_abort) begin
                    d_busy = 1'b0; d_req = 1'b0;
                end else if (d_ack) begin
                    d_busy = 1'b0; d_req = 1'b0;
                end else begin
                    if (drop_pend) begin
                        d_req = 1'b0; drop_pend = 1'b0;
                    end
                    wdog++;
                    if (wdog > 60) begin
                        fail_now("d_ack_timeout");
                        d_busy = 1'b0; d_req = 1'b0;
                    end
                end
            end
            if (!d_busy && !drv_abort && d_stim_q.size() > 0) begin
                it = d_stim_q.pop_front();
                d_we = it.we; d_addr = it.addr; d_wdata = it.wdata;
                d_req = 1'b1; d_busy = 1'b1; wdog = 0; drop_pend = it.drop;
            end
        end
    end

    // Monitor: grants, hold stability, acks and stall outputs.
    initial begin
        grant_t cur_g;
        logic   m_req_q;
        m_req_q = 1'b0;
        cur_g.we = 1'b0; cur_g.addr = '0; cur_g.wdata = '0; cur_g.chk_wdata = 1'b0;
        forever begin
            @(negedge clk);
            if (m_req === 1'b1 && m_req_q !== 1'b1) begin
                if (grant_q.size() == 0) begin
                    fail_now("unexpected_grant");
                end else begin
                    cur_g = grant_q.pop_front();
                    check("grant_we", m_we, cur_g.we);
                    check("grant_addr", m_addr, cur_g.addr);
                    if (cur_g.chk_wdata) check("grant_wdata", m_wdata, cur_g.wdata);
                end
            end else if (m_req === 1'b1) begin
                check("hold_we", m_we, cur_g.we);
                check("hold_addr", m_addr, cur_g.addr);
                if (cur_g.chk_wdata) check("hold_wdata", m_wdata, cur_g.wdata);
            end
            m_req_q = m_req;
            if (if_ack === 1'b1) begin
                if_ack_cnt++;
                if (if_exp_q.size() == 0) fail_now("unexpected_if_ack");
                else check("if_rdata", if_rdata, if_exp_q.pop_front());
            end
            if (d_ack === 1'b1) begin
                d_ack_cnt++;
                d_prev_ack_cyc = d_last_ack_cyc;
                d_last_ack_cyc = cyc;
                if (d_exp_q.size() == 0) fail_now("unexpected_d_ack");
                else check("d_rdata", d_rdata, d_exp_q.pop_front());
            end
            check("stall_if", stall_if, if_req & ~if_ack);
            check("stall_mem", stall_mem, d_req & ~d_ack);
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout (cycle %0d)", cyc);
        $fatal(1, "bench did not finish");
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_m_req"}, m_req, 0);
        check({tag, "_m_we"}, m_we, 0);
        check({tag, "_m_addr"}, m_addr, 0);
        check({tag, "_m_wdata"}, m_wdata, 0);
        check({tag, "_if_ack"}, if_ack, 0);
        check({tag, "_d_ack"}, d_ack, 0);
        check({tag, "_if_rdata"}, if_rdata, 0);
        check({tag, "_d_rdata"}, d_rdata, 0);
    endtask

    initial begin
        int n;
        int ack0;
        reset = 1'b1;
        mem[32'h40]  = 32'h2001_0005;
        mem[32'h80]  = 32'h1300_0093;
        mem[32'h200] = 32'h1122_3344;
        mem[32'h500] = 32'hF000_0000;
        mem[32'h504] = 32'hF000_0001;
        for (int i = 0; i < 7; i++) mem[32'h400 + 4 * i] = 32'hA000_0000 + i;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        // Fetch only: 3-cycle latency, m_we low.
        exp_grant(1'b0, 32'h40, '0, 1'b0);
        if_exp_q.push_back(32'h2001_0005);
        if_stim_q.push_back(32'h40);
        wait_idle("fetch_only");
        check("fetch_latency", if_last_lat, 3);

        // Simultaneous store + fetch: store wins, fetch follows.
        exp_grant(1'b1, 32'h100, 32'hDEAD_BEEF, 1'b1);
        exp_grant(1'b0, 32'h80, '0, 1'b0);
        d_exp_q.push_back(32'h0);
        if_exp_q.push_back(32'h1300_0093);
        push_d(1'b1, 32'h100, 32'hDEAD_BEEF, 1'b0);
        if_stim_q.push_back(32'h80);
        wait_idle("simultaneous");

        // Back-to-back load then store: load sees stored data, store holds d_rdata.
        exp_grant(1'b0, 32'h100, 32'h0, 1'b1);
        exp_grant(1'b1, 32'h104, 32'h0BAD_F00D, 1'b1);
        d_exp_q.push_back(32'hDEAD_BEEF);
        d_exp_q.push_back(32'hDEAD_BEEF);
        push_d(1'b0, 32'h100, 32'h0, 1'b0);
        push_d(1'b1, 32'h104, 32'h0BAD_F00D, 1'b0);
        wait_idle("back_to_back");
        check("throughput_spacing", d_last_ack_cyc - d_prev_ack_cyc, 3);

        // Starvation: three data grants, forced fetch, counter restarts.
        for (int i = 0; i < 3; i++) exp_grant(1'b0, 32'h400 + 4 * i, '0, 1'b1);
        exp_grant(1'b0, 32'h500, '0, 1'b0);
        for (int i = 3; i < 6; i++) exp_grant(1'b0, 32'h400 + 4 * i, '0, 1'b1);
        exp_grant(1'b0, 32'h504, '0, 1'b0);
        exp_grant(1'b0, 32'h418, '0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            d_exp_q.push_back(32'hA000_0000 + i);
            push_d(1'b0, 32'h400 + 4 * i, '0, 1'b0);
        end
        if_exp_q.push_back(32'hF000_0000);
        if_exp_q.push_back(32'hF000_0001);
        if_stim_q.push_back(32'h500);
        if_stim_q.push_back(32'h504);
        wait_idle("starvation");

        // Slow memory: request held 5 cycles, single ack.
        lat  = 5;
        ack0 = if_ack_cnt;
        exp_grant(1'b0, 32'h200, '0, 1'b0);
        if_exp_q.push_back(32'h1122_3344);
        if_stim_q.push_back(32'h200);
        wait_idle("slow_mem");
        check("slow_ack_count", if_ack_cnt - ack0, 1);
        check("slow_latency", if_last_lat, 7);
        lat = 1;

        // Requester drops d_req while granted: access still completes.
        ack0 = d_ack_cnt;
        exp_grant(1'b0, 32'h40, '0, 1'b1);
        d_exp_q.push_back(32'h2001_0005);
        push_d(1'b0, 32'h40, '0, 1'b1);
        wait_idle("req_drop");
        check("drop_ack_count", d_ack_cnt - ack0, 1);

        // Stray m_ack in IDLE is ignored.
        ack0 = if_ack_cnt + d_ack_cnt;
        inject_req++;
        repeat (4) @(negedge clk);
        check("stray_ack_count", if_ack_cnt + d_ack_cnt - ack0, 0);
        check("stray_m_req", m_req, 0);
        check("stray_if_rdata", if_rdata, 32'h1122_3344);

        // Reset during BUSY_D: access abandoned, late m_ack ignored.
        lat  = 4;
        ack0 = d_ack_cnt;
        exp_grant(1'b0, 32'h40, '0, 1'b1);
        push_d(1'b0, 32'h40, '0, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (m_req !== 1'b1 && n < 20);
        if (n >= 20) fail_now("reset_mid_no_grant");
        reset     = 1'b1;
        drv_abort = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        drv_abort = 1'b0;
        check_all_zero("reset_mid");
        repeat (6) @(negedge clk);
        check("reset_mid_no_d_ack", d_ack_cnt - ack0, 0);
        check_all_zero("after_late_ack");
        lat = 1;

        // Arbiter is back in IDLE: a fresh fetch sees best-case latency.
        exp_grant(1'b0, 32'h40, '0, 1'b0);
        if_exp_q.push_back(32'h2001_0005);
        if_stim_q.push_back(32'h40);
        wait_idle("post_reset_fetch");
        check("post_reset_latency", if_last_lat, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
